// File: rtl/grid_io_pkg.sv
// Shared types and helpers for the configurable IO grid tile.
// Holds the controller state encoding, config row indices and the row-address width rule.
package grid_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int CFG_ROW_DIR = 0;
    localparam int CFG_ROW_INV = 1;

    // Row address needs at least one bit even for a single-row bank.
    function automatic int cfg_row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/grid_io_pad_cell.sv
// One GPIO subtile: its column of config cells plus pad direction / input polarity logic.
// Optional GRID_IO_CFG_READBACK_EN exposes the stored column for the readback mux.
module grid_io_pad_cell
    import grid_io_pkg::*;
#(
    parameter int CFG_ROWS = 2
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic [CFG_ROWS-1:0] wl,
    input  logic                bl,
    input  logic                outpad,
    output logic                inpad,
`ifdef GRID_IO_CFG_READBACK_EN
    output logic [CFG_ROWS-1:0] cell_mem,
`endif
    inout  wire                 pad
);

    logic [CFG_ROWS-1:0] mem_reg;
    logic                dir;
    logic                inv;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            mem_reg <= '0;
        end else begin
            for (int r = 0; r < CFG_ROWS; r++) begin
                if (wl[r]) begin
                    mem_reg[r] <= bl;
                end
            end
        end
    end

    assign dir = mem_reg[CFG_ROW_DIR];

    // A single-row bank has no polarity cell, so inputs pass straight through.
    if (CFG_ROWS >= 2) begin : g_inv
        assign inv = mem_reg[CFG_ROW_INV];
    end else begin : g_no_inv
        assign inv = 1'b0;
    end

    assign pad   = dir ? outpad : 1'bz;
    assign inpad = dir ? 1'b0 : (pad ^ inv);

`ifdef GRID_IO_CFG_READBACK_EN
    assign cell_mem = mem_reg;
`endif

endmodule

// File: rtl/grid_io_bank_cfg.sv
// IO grid tile: NUM_SUBTILE pad cells fed by a sequenced bl/wl configuration write controller.
// Define GRID_IO_CFG_READBACK_EN to add the cfg_rd_* row readback port.
module grid_io_bank_cfg
    import grid_io_pkg::*;
#(
    parameter int NUM_SUBTILE = 8,
    parameter int CFG_ROWS    = 2,
    parameter int WL_PULSE    = 2,
    parameter int ROW_W       = cfg_row_width(CFG_ROWS)
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ROW_W-1:0]       cfg_row,
    input  logic [NUM_SUBTILE-1:0] cfg_data,
    output logic                   cfg_busy,
    output logic                   cfg_err,
`ifdef GRID_IO_CFG_READBACK_EN
    input  logic                   cfg_rd_req,
    input  logic [ROW_W-1:0]       cfg_rd_row,
    output logic                   cfg_rd_valid,
    output logic [NUM_SUBTILE-1:0] cfg_rd_data,
`endif
    inout  wire  [NUM_SUBTILE-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_SUBTILE-1:0] io_outpad,
    output logic [NUM_SUBTILE-1:0] io_inpad
);

    state_t                 state_reg, state_next;
    logic [ROW_W-1:0]       row_reg, row_next;
    logic [NUM_SUBTILE-1:0] data_reg, data_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic                   err_reg, err_next;
    logic [NUM_SUBTILE-1:0] bl;
    logic [CFG_ROWS-1:0]    wl;
    logic                   accept;
    logic                   row_oor;

    assign accept  = cfg_valid && cfg_ready;
    assign row_oor = 32'(cfg_row) >= CFG_ROWS;
    assign cfg_err = err_reg;

`ifdef GRID_IO_CFG_READBACK_EN
    logic [NUM_SUBTILE-1:0][CFG_ROWS-1:0] cell_mem;
    logic [NUM_SUBTILE-1:0]               rd_word;
    logic                                 rd_oor;
    logic                                 rd_fire;
    logic                                 rd_valid_reg;
    logic [NUM_SUBTILE-1:0]               rd_data_reg;

    assign rd_oor  = 32'(cfg_rd_row) >= CFG_ROWS;
    assign rd_fire = (state_reg == IDLE) && cfg_rd_req;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_SUBTILE; i++) begin
            rd_word[i] = cell_mem[i][cfg_rd_row];
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_fire;
            rd_data_reg  <= (rd_fire && !rd_oor) ? rd_word : '0;
        end
    end

    assign cfg_rd_valid = rd_valid_reg;
    assign cfg_rd_data  = rd_data_reg;
`endif

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
`ifdef GRID_IO_CFG_READBACK_EN
                if (cfg_rd_req && rd_oor) begin
                    err_next = 1'b1;
                end
`endif
                // An out-of-range write is consumed and flagged, never sequenced.
                if (accept) begin
                    if (row_oor) begin
                        err_next = 1'b1;
                    end else begin
                        row_next   = cfg_row;
                        data_next  = cfg_data;
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_next   = 4'(WL_PULSE - 1);
                state_next = PULSE;
            end
            PULSE: begin
                if (cnt_reg == 4'd0) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            HOLD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        cfg_ready = (state_reg == IDLE);
`ifdef GRID_IO_CFG_READBACK_EN
        cfg_ready = (state_reg == IDLE) && !cfg_rd_req;
`endif
        cfg_busy  = (state_reg != IDLE);
        bl        = (state_reg == IDLE) ? '0 : data_reg;
        wl        = '0;
        if (state_reg == PULSE) begin
            wl = CFG_ROWS'(1) << row_reg;
        end
    end

    for (genvar gi = 0; gi < NUM_SUBTILE; gi++) begin : g_cell
        grid_io_pad_cell #(
            .CFG_ROWS(CFG_ROWS)
        ) u_cell (
            .prog_clk (prog_clk),
            .pReset   (pReset),
            .wl       (wl),
            .bl       (bl[gi]),
            .outpad   (io_outpad[gi]),
            .inpad    (io_inpad[gi]),
`ifdef GRID_IO_CFG_READBACK_EN
            .cell_mem (cell_mem[gi]),
`endif
            .pad      (gfpga_pad_GPIO_PAD[gi])
        );
    end

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Scoreboard bench for grid_io_bank_cfg: stimulus queues predicted pad/flag outcomes per
// write, a monitor pops them on each observed handshake. Readback checks under GRID_IO_CFG_READBACK_EN.
module tb_grid_io_bank_cfg;

    localparam int N    = 8;
    localparam int ROWS = 3;  // one spare row keeps index 3 out of range with a 2-bit address
    localparam int WLP  = 2;
    localparam int RW   = 2;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [N-1:0]  data;
        logic          oor;
        logic          b2b;
        logic [N-1:0]  in_before;
        logic [N-1:0]  mask_before;
        logic [N-1:0]  in_after;
        logic [N-1:0]  pad_after;
        logic [N-1:0]  mask_after;
        logic          err_after;
    } wr_exp_t;

    logic          prog_clk  = 1'b0;
    logic          pReset    = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready, cfg_busy, cfg_err;
    logic [RW-1:0] cfg_row   = '0;
    logic [N-1:0]  cfg_data  = '0;
    logic [N-1:0]  io_outpad = '0;
    logic [N-1:0]  io_inpad;
    logic [N-1:0]  tb_en     = '1;
    logic [N-1:0]  tb_val    = '0;
    wire  [N-1:0]  pad;

    logic [N-1:0]  m_mem [ROWS];
    logic          m_err = 1'b0;
    wr_exp_t       wq[$];
    int            checks = 0;
    int            errors = 0;

`ifdef GRID_IO_CFG_READBACK_EN
    logic          cfg_rd_req = 1'b0;
    logic [RW-1:0] cfg_rd_row = '0;
    logic          cfg_rd_valid;
    logic [N-1:0]  cfg_rd_data;
    logic [N-1:0]  rq[$];
`endif

    grid_io_bank_cfg #(
        .NUM_SUBTILE(N),
        .CFG_ROWS   (ROWS),
        .WL_PULSE   (WLP)
    ) dut (
        .prog_clk          (prog_clk),
        .pReset            (pReset),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_row           (cfg_row),
        .cfg_data          (cfg_data),
        .cfg_busy          (cfg_busy),
        .cfg_err           (cfg_err),
`ifdef GRID_IO_CFG_READBACK_EN
        .cfg_rd_req        (cfg_rd_req),
        .cfg_rd_row        (cfg_rd_row),
        .cfg_rd_valid      (cfg_rd_valid),
        .cfg_rd_data       (cfg_rd_data),
`endif
        .gfpga_pad_GPIO_PAD(pad),
        .io_outpad         (io_outpad),
        .io_inpad          (io_inpad)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_drv
        assign pad[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
    end

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Pads the bench does not drive and the DUT leaves floating are masked out.
    function automatic void predict(output logic [N-1:0] inp, output logic [N-1:0] pv,
                                    output logic [N-1:0] msk);
        logic [N-1:0] dir, inv;
        dir = m_mem[0];
        inv = m_mem[1];
        inp = ~dir & (tb_val ^ inv);
        pv  = (dir & io_outpad) | (~dir & tb_val);
        msk = dir | tb_en;
    endfunction

    task automatic wait_accept();
        int n = 0;
        while (1) begin
            @(negedge prog_clk);
            if (cfg_ready) break;
            n++;
            if (n > 30) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got cfg_ready=0 for %0d cycles required 1", n);
                break;
            end
        end
        @(posedge prog_clk);
        #1;
    endtask

    task automatic issue(input logic [RW-1:0] row, input logic [N-1:0] data, input logic b2b);
        wr_exp_t      e;
        logic [N-1:0] scratch;
        e.row  = row;
        e.data = data;
        e.b2b  = b2b;
        e.oor  = (int'(row) >= ROWS);
        predict(e.in_before, scratch, e.mask_before);
        if (e.oor) m_err = 1'b1;
        else       m_mem[row] = data;
        predict(e.in_after, e.pad_after, e.mask_after);
        e.err_after = m_err;
        wq.push_back(e);
        cfg_row   = row;
        cfg_data  = data;
        cfg_valid = 1'b1;
        wait_accept();
    endtask

    task automatic run_txn(input logic [RW-1:0] row, input logic [N-1:0] data,
                           input logic [N-1:0] val, input logic [N-1:0] outp);
        io_outpad = outp;
        tb_val    = val;
        tb_en     = ~(m_mem[0] | ((row == 0) ? data : '0));
        issue(row, data, 1'b0);
        cfg_valid = 1'b0;
        repeat (WLP + 3) @(posedge prog_clk);
        #1;
    endtask

    task automatic run_pair(input logic [RW-1:0] r1, input logic [N-1:0] d1,
                            input logic [RW-1:0] r2, input logic [N-1:0] d2);
        io_outpad = N'($urandom);
        tb_val    = N'($urandom);
        tb_en     = ~(m_mem[0] | ((r1 == 0) ? d1 : '0) | ((r2 == 0) ? d2 : '0));
        issue(r1, d1, 1'b0);
        issue(r2, d2, 1'b1);
        cfg_valid = 1'b0;
        repeat (WLP + 3) @(posedge prog_clk);
        #1;
    endtask

    task automatic reset_mid_write();
        io_outpad = N'($urandom);
        tb_val    = N'($urandom);
        tb_en     = ~(m_mem[0] | 8'hF0);
        issue(2'd0, 8'hF0, 1'b0);
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        pReset = 1'b1;
        for (int r = 0; r < ROWS; r++) m_mem[r] = '0;
        m_err = 1'b0;
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        tb_en  = '1;
        repeat (3) @(posedge prog_clk);
        #1;
    endtask

    initial begin : monitor
        wr_exp_t e;
        int      cyc = 0;
        int      last_acc = -100;
        int      low;
        bit      rst_seen = 1'b0;
        bit      idle_pend = 1'b0;
        bit      aborted;
        logic    idle_err = 1'b0;
        forever begin
            @(negedge prog_clk);
            cyc++;
            if (pReset) begin
                rst_seen  = 1'b1;
                idle_pend = 1'b0;
                continue;
            end
            if (rst_seen) begin
                rst_seen = 1'b0;
                chk("rst_ready_busy_err", {cfg_ready, cfg_busy, cfg_err}, 3'b100);
                chk("rst_wl", 32'(dut.wl), 0);
                chk("rst_inpad", io_inpad, tb_val);
            end
            if (idle_pend) begin
                idle_pend = 1'b0;
                chk("idle_ready_busy_err", {cfg_ready, cfg_busy, cfg_err}, {2'b10, idle_err});
            end
`ifdef GRID_IO_CFG_READBACK_EN
            if (cfg_rd_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got cfg_rd_valid=1 required 0");
                end else begin
                    logic [N-1:0] rexp;
                    rexp = rq.pop_front();
                    $display("rd data=%h", cfg_rd_data);
                    chk("rd_data", cfg_rd_data, rexp);
                end
            end
`endif
            if (cfg_valid && cfg_ready) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got accept with row=%0d required none", cfg_row);
                    continue;
                end
                e = wq.pop_front();
                $display("wr row=%0d data=%h oor=%0d b2b=%0d", e.row, e.data, e.oor, e.b2b);
                if (e.b2b) chk("accept_to_accept", cyc - last_acc, WLP + 3);
                last_acc = cyc;
                if (e.oor) begin
                    @(negedge prog_clk);
                    cyc++;
                    chk("oor_ready_busy_err", {cfg_ready, cfg_busy, cfg_err}, {2'b10, e.err_after});
                    chk("oor_mem_unchanged", io_inpad & e.mask_after, e.in_after & e.mask_after);
                    continue;
                end
                low     = 0;
                aborted = 1'b0;
                for (int k = 1; k <= WLP + 2; k++) begin
                    @(negedge prog_clk);
                    cyc++;
                    if (pReset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!cfg_ready && cfg_busy) low++;
                    if (k == 2)
                        chk("inpad_not_yet", io_inpad & e.mask_before, e.in_before & e.mask_before);
                    if (k == 3) begin
                        chk("inpad_after", io_inpad & e.mask_after, e.in_after & e.mask_after);
                        chk("pad_after", pad & e.mask_after, e.pad_after & e.mask_after);
                    end
                end
                if (aborted) begin
                    rst_seen = 1'b1;
                    continue;
                end
                chk("busy_cycles", low, WLP + 2);
                idle_pend = 1'b1;
                idle_err  = e.err_after;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int r = 0; r < ROWS; r++) m_mem[r] = '0;
        tb_val = N'($urandom);
        repeat (3) @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;

        run_txn(2'd0, 8'hA5, N'($urandom), N'($urandom));
        run_txn(2'd0, 8'h00, 8'h3C, N'($urandom));
        run_txn(2'd1, 8'hFF, 8'h3C, N'($urandom));
        run_txn(2'd3, 8'h77, 8'h3C, N'($urandom));
        reset_mid_write();

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0)
                run_pair(RW'($urandom_range(0, 2)), N'($urandom),
                         RW'($urandom_range(0, 3)), N'($urandom));
            else
                run_txn(RW'($urandom_range(0, 3)), N'($urandom), N'($urandom), N'($urandom));
        end

`ifdef GRID_IO_CFG_READBACK_EN
        run_txn(2'd0, 8'h5A, N'($urandom), N'($urandom));
        rq.push_back(8'h5A);
        cfg_rd_row = 2'd0;
        cfg_rd_req = 1'b1;
        @(posedge prog_clk);
        #1;
        cfg_rd_req = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        rq.push_back('0);
        m_err      = 1'b1;
        cfg_rd_row = 2'd3;
        cfg_rd_req = 1'b1;
        @(posedge prog_clk);
        #1;
        cfg_rd_req = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        rq.push_back(m_mem[2]);
        cfg_rd_row = 2'd2;
        cfg_rd_req = 1'b1;
        fork
            begin
                @(negedge prog_clk);
                chk("rd_blocks_write", cfg_ready, 0);
                @(posedge prog_clk);
                #1 cfg_rd_req = 1'b0;
            end
        join_none
        run_txn(2'd1, 8'h81, N'($urandom), N'($urandom));
        chk("rd_queue_drained", rq.size(), 0);
`endif

        repeat (4) @(posedge prog_clk);
        #1;
        chk("write_queue_drained", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
